// File: rtl/cursor_action_ctrl.sv
// Board cursor / click action controller: moves the cursor or raises a reveal/flag request, then
// pulses ACK once per action code; moves ACK one cycle after the edge, requests wait on CellDone or timeout.
module cursor_action_ctrl #(
   parameter int ROWS      = 16,
   parameter int COLS      = 16,
   parameter int ROW_W     = 4,
   parameter int COL_W     = 4,
   parameter int START_ROW = 0,
   parameter int START_COL = 0,
   parameter int TIMEOUT   = 255
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [2:0]       Action,
   input  logic             GameActive,
   input  logic             CellDone,
   output logic [ROW_W-1:0] CurRow,
   output logic [COL_W-1:0] CurCol,
   output logic             RevealReq,
   output logic             FlagReq,
   output logic             ACK,
   output logic             Busy,
   output logic             Err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_INIT  = ROW_W'(START_ROW);
   localparam logic [COL_W-1:0] COL_INIT  = COL_W'(START_COL);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   localparam logic [2:0] ACT_NONE   = 3'b000;
   localparam logic [2:0] ACT_CLICK  = 3'b001;
   localparam logic [2:0] ACT_DCLICK = 3'b010;
   localparam logic [2:0] ACT_UP     = 3'b100;
   localparam logic [2:0] ACT_RIGHT  = 3'b101;
   localparam logic [2:0] ACT_DOWN   = 3'b110;
   localparam logic [2:0] ACT_LEFT   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_ACKS,
      S_WREL
   } state_t;

   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             reveal_q, reveal_d;
   logic             flag_q, flag_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   logic [ROW_W-1:0] row_up, row_dn;
   logic [COL_W-1:0] col_lf, col_rt;
   logic             cnt_hit;

   // Wrapped neighbours of the current cursor position.
   always_comb begin
      row_up = (row_q == '0)       ? ROW_LAST : row_q - ROW_W'(1);
      row_dn = (row_q >= ROW_LAST) ? '0       : row_q + ROW_W'(1);
      col_lf = (col_q == '0)       ? COL_LAST : col_q - COL_W'(1);
      col_rt = (col_q >= COL_LAST) ? '0       : col_q + COL_W'(1);
   end

   assign cnt_hit = ((cnt_q + CNT_W'(1)) == CNT_LIMIT);

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      cnt_d    = cnt_q;
      reveal_d = reveal_q;
      flag_d   = flag_q;
      err_d    = err_q;
      ack_d    = 1'b0;
      busy_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (Action != ACT_NONE) begin
               state_d = S_ACKS;
               if (GameActive) begin
                  case (Action)
                     ACT_CLICK: begin
                        reveal_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_REQ;
                     end
                     ACT_DCLICK: begin
                        flag_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REQ;
                     end
                     ACT_UP:    row_d = row_up;
                     ACT_DOWN:  row_d = row_dn;
                     ACT_LEFT:  col_d = col_lf;
                     ACT_RIGHT: col_d = col_rt;
                     default:   ;
                  endcase
               end
            end
         end
         S_REQ: begin
            // CellDone wins over a timeout landing on the same edge.
            if (CellDone || cnt_hit) begin
               reveal_d = 1'b0;
               flag_d   = 1'b0;
               state_d  = S_ACKS;
               if (!CellDone) begin
                  err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ACKS: begin
            state_d = S_WREL;
         end
         S_WREL: begin
            if (Action == ACT_NONE) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d  = S_IDLE;
            reveal_d = 1'b0;
            flag_d   = 1'b0;
         end
      endcase

      ack_d  = (state_d == S_ACKS);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q  <= S_IDLE;
         row_q    <= ROW_INIT;
         col_q    <= COL_INIT;
         cnt_q    <= '0;
         reveal_q <= 1'b0;
         flag_q   <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         cnt_q    <= cnt_d;
         reveal_q <= reveal_d;
         flag_q   <= flag_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign CurRow    = row_q;
   assign CurCol    = col_q;
   assign RevealReq = reveal_q;
   assign FlagReq   = flag_q;
   assign ACK       = ack_q;
   assign Busy      = busy_q;
   assign Err       = err_q;

endmodule

// File: tb/tb_cursor_action_ctrl.sv
// Bench for cursor_action_ctrl: a 16x16 instance plus a 5x6 instance (non power-of-two wrap),
// both driven by the same action stream; expected cursor/Err states are queued and compared at ACK.
module tb_cursor_action_ctrl;

   localparam int R1 = 16;
   localparam int C1 = 16;
   localparam int R2 = 5;
   localparam int C2 = 6;

   logic       clk = 1'b0;
   logic       clear;
   logic [2:0] Action;
   logic       GameActive;
   logic       CellDone;

   logic [3:0] CurRow, CurCol;
   logic       RevealReq, FlagReq, ACK, Busy, Err;
   logic [2:0] CurRow2, CurCol2;
   logic       RevealReq2, FlagReq2, ACK2, Busy2, Err2;

   int n_checks = 0;
   int n_fail   = 0;

   int m_row, m_col, m2_row, m2_col;

   typedef struct {
      int   row;
      int   col;
      int   row2;
      int   col2;
      logic err;
   } exp_t;

   exp_t sb[$];

   cursor_action_ctrl #(
      .ROWS(R1), .COLS(C1), .ROW_W(4), .COL_W(4),
      .START_ROW(3), .START_COL(5), .TIMEOUT(4)
   ) dut (
      .clk(clk), .clear(clear), .Action(Action), .GameActive(GameActive), .CellDone(CellDone),
      .CurRow(CurRow), .CurCol(CurCol), .RevealReq(RevealReq), .FlagReq(FlagReq),
      .ACK(ACK), .Busy(Busy), .Err(Err)
   );

   cursor_action_ctrl #(
      .ROWS(R2), .COLS(C2), .ROW_W(3), .COL_W(3),
      .START_ROW(0), .START_COL(0), .TIMEOUT(4)
   ) dut2 (
      .clk(clk), .clear(clear), .Action(Action), .GameActive(GameActive), .CellDone(CellDone),
      .CurRow(CurRow2), .CurCol(CurCol2), .RevealReq(RevealReq2), .FlagReq(FlagReq2),
      .ACK(ACK2), .Busy(Busy2), .Err(Err2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference cursor model for both instances.
   task automatic model_move(input logic [2:0] a);
      case (a)
         3'b100: begin m_row = (m_row + R1 - 1) % R1; m2_row = (m2_row + R2 - 1) % R2; end
         3'b110: begin m_row = (m_row + 1) % R1;      m2_row = (m2_row + 1) % R2;      end
         3'b111: begin m_col = (m_col + C1 - 1) % C1; m2_col = (m2_col + C2 - 1) % C2; end
         3'b101: begin m_col = (m_col + 1) % C1;      m2_col = (m2_col + 1) % C2;      end
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_row = 3; m_col = 5; m2_row = 0; m2_col = 0;
   endtask

   task automatic push_exp(input logic err);
      exp_t e;
      e.row = m_row; e.col = m_col; e.row2 = m2_row; e.col2 = m2_col; e.err = err;
      sb.push_back(e);
   endtask

   function automatic logic [14:0] pack_exp(input exp_t e);
      return {4'(e.row), 4'(e.col), 3'(e.row2), 3'(e.col2), e.err};
   endfunction

   function automatic logic [14:0] pack_dut();
      return {CurRow, CurCol, CurRow2, CurCol2, Err};
   endfunction

   // Samples on negedges until ACK is seen or the budget runs out.
   task automatic wait_ack(input int budget, output bit seen, output int n_rev,
                           output int n_flag, output int n_cyc);
      seen = 1'b0; n_rev = 0; n_flag = 0; n_cyc = 0;
      while (!seen && n_cyc < budget) begin
         @(negedge clk);
         n_cyc++;
         if (RevealReq === 1'b1) n_rev++;
         if (FlagReq === 1'b1) n_flag++;
         if (ACK === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic release_action(input int hold, output int extra_acks);
      extra_acks = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (ACK !== 1'b0) extra_acks++;
      end
      Action = 3'b000;
      repeat (2) begin
         @(negedge clk);
         if (ACK !== 1'b0) extra_acks++;
      end
   endtask

   task automatic test_reset();
      clear = 1'b1; Action = 3'b000; GameActive = 1'b1; CellDone = 1'b0;
      #12;
      n_checks++;
      if ({CurRow, CurCol} !== {4'd3, 4'd5}) begin
         n_fail++; $display("FAIL reset_cursor: got %0d,%0d expected 3,5", CurRow, CurCol);
      end
      n_checks++;
      if ({RevealReq, FlagReq, ACK, Busy, Err} !== 5'b00000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 00000", {RevealReq, FlagReq, ACK, Busy, Err});
      end
      n_checks++;
      if ({CurRow2, CurCol2} !== 6'd0) begin
         n_fail++; $display("FAIL reset_cursor2: got %0d,%0d expected 0,0", CurRow2, CurCol2);
      end
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({Busy, ACK} !== 2'b00) begin
         n_fail++; $display("FAIL reset_idle: got busy=%b ack=%b expected 0,0", Busy, ACK);
      end
   endtask

   task automatic test_move_up();
      bit seen; int nr, nf, nc, extra; exp_t e;
      Action = 3'b100;
      model_move(Action);
      push_exp(1'b0);
      wait_ack(8, seen, nr, nf, nc);
      n_checks++;
      if (!seen || nc != 1) begin
         n_fail++; $display("FAIL up_latency: seen=%0d cycles=%0d expected seen=1 cycles=1", seen, nc);
      end
      e = sb.pop_front();
      n_checks++;
      if (pack_dut() !== pack_exp(e)) begin
         n_fail++; $display("FAIL up_cursor: got %h expected %h", pack_dut(), pack_exp(e));
      end
      release_action(0, extra);
      n_checks++;
      if (extra != 0 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL up_release: extra_acks=%0d busy=%b expected 0,0", extra, Busy);
      end
   endtask

   task automatic test_wrap();
      logic [2:0] seq [0:10];
      bit seen; int nr, nf, nc, extra; exp_t e;
      seq = '{3'b100, 3'b100, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
              3'b111, 3'b100, 3'b110, 3'b101};
      for (int i = 0; i < 11; i++) begin
         Action = seq[i];
         model_move(Action);
         push_exp(1'b0);
         wait_ack(8, seen, nr, nf, nc);
         e = sb.pop_front();
         n_checks++;
         if (!seen || pack_dut() !== pack_exp(e)) begin
            n_fail++;
            $display("FAIL wrap_step%0d: seen=%0d got %h expected %h", i, seen, pack_dut(), pack_exp(e));
         end
         release_action(0, extra);
         n_checks++;
         if (extra != 0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL wrap_release%0d: extra_acks=%0d busy=%b expected 0,0", i, extra, Busy);
         end
      end
   endtask

   task automatic test_reveal_flag();
      int extra, held; exp_t e; logic [3:0] exp_req; logic [2:0] act;
      CellDone = 1'b1;
      @(negedge clk);
      CellDone = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({Busy, ACK} !== 2'b00) begin
         n_fail++; $display("FAIL idle_celldone: busy=%b ack=%b expected 0,0", Busy, ACK);
      end
      for (int k = 0; k < 2; k++) begin
         act     = (k == 0) ? 3'b001 : 3'b010;
         exp_req = (k == 0) ? 4'b1001 : 4'b0101;
         Action = act;
         push_exp(1'b0);
         @(negedge clk);
         n_checks++;
         if ({RevealReq, FlagReq, ACK, Busy} !== exp_req) begin
            n_fail++; $display("FAIL req_rise%0d: got %b expected %b", k, {RevealReq, FlagReq, ACK, Busy}, exp_req);
         end
         held = 0;
         repeat (2) begin
            @(negedge clk);
            if ({RevealReq, FlagReq, ACK, Busy} === exp_req) held++;
         end
         n_checks++;
         if (held != 2) begin
            n_fail++; $display("FAIL req_hold%0d: held %0d cycles expected 2", k, held);
         end
         CellDone = 1'b1;
         @(negedge clk);
         CellDone = 1'b0;
         n_checks++;
         if ({RevealReq, FlagReq, ACK} !== 3'b001) begin
            n_fail++; $display("FAIL req_done%0d: got %b expected 001", k, {RevealReq, FlagReq, ACK});
         end
         e = sb.pop_front();
         n_checks++;
         if (pack_dut() !== pack_exp(e)) begin
            n_fail++; $display("FAIL req_cursor%0d: got %h expected %h", k, pack_dut(), pack_exp(e));
         end
         release_action(0, extra);
         n_checks++;
         if (extra != 0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL req_release%0d: extra_acks=%0d busy=%b expected 0,0", k, extra, Busy);
         end
      end
   endtask

   task automatic test_timeout();
      bit seen; int nr, nf, nc, extra; exp_t e;
      Action = 3'b001;
      push_exp(1'b1);
      wait_ack(20, seen, nr, nf, nc);
      n_checks++;
      if (!seen || nr != 4 || nc != 5) begin
         n_fail++; $display("FAIL timeout_len: seen=%0d req_cycles=%0d ack_at=%0d expected 1,4,5", seen, nr, nc);
      end
      e = sb.pop_front();
      n_checks++;
      if (pack_dut() !== pack_exp(e) || RevealReq !== 1'b0) begin
         n_fail++; $display("FAIL timeout_state: got %h req=%b expected %h req=0", pack_dut(), RevealReq, pack_exp(e));
      end
      release_action(0, extra);
      n_checks++;
      if (extra != 0 || Busy !== 1'b0 || Err !== 1'b1) begin
         n_fail++; $display("FAIL timeout_release: extra=%0d busy=%b err=%b expected 0,0,1", extra, Busy, Err);
      end
      Action = 3'b101;
      model_move(Action);
      push_exp(1'b1);
      wait_ack(8, seen, nr, nf, nc);
      e = sb.pop_front();
      n_checks++;
      if (!seen || pack_dut() !== pack_exp(e)) begin
         n_fail++; $display("FAIL timeout_move: seen=%0d got %h expected %h", seen, pack_dut(), pack_exp(e));
      end
      release_action(0, extra);
   endtask

   task automatic test_inactive_undef();
      logic [2:0] acts [0:2];
      logic       gas  [0:2];
      bit seen; int nr, nf, nc, extra; exp_t e;
      acts = '{3'b001, 3'b100, 3'b011};
      gas  = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         GameActive = gas[i];
         Action = acts[i];
         push_exp(1'b1);
         wait_ack(8, seen, nr, nf, nc);
         n_checks++;
         if (!seen || nc != 1 || nr != 0 || nf != 0) begin
            n_fail++;
            $display("FAIL noop%0d: seen=%0d ack_at=%0d rev=%0d flag=%0d expected 1,1,0,0", i, seen, nc, nr, nf);
         end
         e = sb.pop_front();
         n_checks++;
         if (pack_dut() !== pack_exp(e)) begin
            n_fail++; $display("FAIL noop_cursor%0d: got %h expected %h", i, pack_dut(), pack_exp(e));
         end
         release_action(0, extra);
         GameActive = 1'b1;
         n_checks++;
         if (extra != 0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL noop_release%0d: extra=%0d busy=%b expected 0,0", i, extra, Busy);
         end
      end
   endtask

   task automatic test_slow_clear();
      bit seen; int nr, nf, nc, extra; exp_t e;
      Action = 3'b110;
      model_move(Action);
      push_exp(1'b1);
      wait_ack(8, seen, nr, nf, nc);
      e = sb.pop_front();
      n_checks++;
      if (!seen || pack_dut() !== pack_exp(e)) begin
         n_fail++; $display("FAIL slow_step: seen=%0d got %h expected %h", seen, pack_dut(), pack_exp(e));
      end
      release_action(5, extra);
      n_checks++;
      if (extra != 0 || Busy !== 1'b0 || pack_dut() !== pack_exp(e)) begin
         n_fail++;
         $display("FAIL slow_single: extra=%0d busy=%b got %h expected 0,0,%h", extra, Busy, pack_dut(), pack_exp(e));
      end
   endtask

   task automatic test_reset_mid_req();
      int acks;
      Action = 3'b001;
      @(negedge clk);
      n_checks++;
      if ({RevealReq, Busy} !== 2'b11) begin
         n_fail++; $display("FAIL midreq_start: got req=%b busy=%b expected 1,1", RevealReq, Busy);
      end
      #2 clear = 1'b1;
      #1;
      n_checks++;
      if ({RevealReq, FlagReq, ACK, Busy, Err} !== 5'b00000 || {CurRow, CurCol} !== {4'd3, 4'd5}) begin
         n_fail++;
         $display("FAIL midreq_clear: flags=%b cursor=%0d,%0d expected 00000 3,5",
                  {RevealReq, FlagReq, ACK, Busy, Err}, CurRow, CurCol);
      end
      Action = 3'b000;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (ACK !== 1'b0) acks++;
      end
      n_checks++;
      if (acks != 0 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL midreq_noack: acks=%0d busy=%b expected 0,0", acks, Busy);
      end
   endtask

   initial begin
      test_reset();
      test_move_up();
      test_wrap();
      test_reveal_flag();
      test_timeout();
      test_inactive_undef();
      test_slow_clear();
      test_reset_mid_req();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cursor_action_ctrl.md
Name: cursor_action_ctrl

Overview:
Downstream consumer of the click-detector stage. Takes the registered 3-bit Action code (000 idle, 001 single centre click, 010 double centre click, 100/101/110/111 U/R/D/L). Moves the board cursor or issues reveal/flag requests to the board-state logic, then returns the one-cycle ACK that clears the detector. The ACK/Action loop is a full handshake: each Action code is consumed exactly once.

Parameters:
ROWS, 16, board rows (≥2)
COLS, 16, board columns (≥2)
ROW_W, 4, cursor row width, ≥ clog2(ROWS)
COL_W, 4, cursor column width, ≥ clog2(COLS)
START_ROW, 0, cursor row after reset
START_COL, 0, cursor column after reset
TIMEOUT, 255, max cycles to wait for CellDone (≥1)

Ports:
clk  in  1  system clock, all state on posedge
clear  in  1  asynchronous active-high reset
Action  in  3  action code from click detector, held until ACK
GameActive  in  1  1 = board accepts input; 0 = actions consumed with no effect
CellDone  in  1  board logic finished current request (single-cycle pulse or level)
CurRow  out  ROW_W  cursor row
CurCol  out  COL_W  cursor column
RevealReq  out  1  request: reveal cell at CurRow/CurCol
FlagReq  out  1  request: toggle flag at CurRow/CurCol
ACK  out  1  one-cycle pulse; clears click detector
Busy  out  1  high in any state other than IDLE
Err  out  1  sticky: request timed out

Behaviour:
- Reset (async, clear=1): state=IDLE, CurRow=START_ROW, CurCol=START_COL. RevealReq, FlagReq, ACK, Busy, Err all 0. Timeout counter = 0. Reset mid-request drops the request immediately; ACK is not issued.
- All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: when Action≠000, branch as follows.
    - GameActive=0, or Action=011 (undefined): go to ACKS.
    - U/D/L/R: update the cursor on this edge, go to ACKS.
    - 001 (single click): set RevealReq, go to REQ.
    - 010 (double click): set FlagReq, go to REQ.
  - REQ: hold the request and freeze the cursor.
    - CellDone=1: drop the request, go to ACKS.
    - Otherwise the counter increments. When it reaches TIMEOUT, drop the request, set Err, go to ACKS.
    - The counter clears on entry.
  - ACKS: ACK=1 for exactly this cycle, go to WREL.
  - WREL: wait for Action=000, then go to IDLE. This guarantees one consumption per action, because the detector clears on the edge after ACK.
- Cursor wrap:
  - U: row-1, with 0 wrapping to ROWS-1.
  - D: row+1, with ROWS-1 wrapping to 0.
  - L/R: the same rule on the column against COLS.
  - Cursor values never leave [0, ROWS-1] / [0, COLS-1].
- Latency:
  - Move: Action seen at edge n → cursor updated and state=ACKS after edge n; ACK high during cycle n+1.
  - Click: req high from edge n. CellDone sampled high at edge m → ACK high in cycle m+1.
- CellDone arriving in IDLE, ACKS or WREL is ignored.
- GameActive falling during REQ does not abort; the request completes or times out.
- At most one of RevealReq/FlagReq is high at any time.
- Err clears only on reset.
- Busy = (state≠IDLE).

Test Plan:
- Reset with START_ROW=3, START_COL=5 → CurRow=3, CurCol=5, all flags 0. Then Action=100 (U), held until ACK → CurRow=2, a single ACK pulse, state back in IDLE after Action returns to 000.
- Wrap: cursor (0,0). Action L → CurCol=15; Action U → CurRow=15; Action D → CurRow=0; Action R at col 15 → CurCol=0.
- Reveal: Action=001 at cycle 10 → RevealReq high from cycle 11. CellDone pulse at cycle 14 → RevealReq low, ACK at cycle 15, cursor unchanged. Repeat with 010 → FlagReq only.
- Timeout: TIMEOUT=4, Action=001, no CellDone → request drops after 4 REQ cycles, Err=1 and stays 1, ACK issued once. A subsequent move still works.
- GameActive=0, Action=001 → no RevealReq, cursor unchanged, ACK pulse. Action=011 → ACK only.
- Action held 5 cycles after ACK (slow clear) → exactly one cursor step. Assert clear during REQ → RevealReq, ACK and Busy drop to 0 asynchronously and the cursor returns to START_ROW/START_COL.
